// File: rtl/bme280_reg_scanner_pkg.sv
// Shared definitions for the BME280 register scanner: FSM encoding, ASCII
// constants, default UART timing and the nibble-to-hex helper.
package bme280_reg_scanner_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 434;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SELECT  = 3'd1;
    localparam logic [2:0] ST_DWELL   = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_SEND    = 3'd4;
    localparam logic [2:0] ST_WAIT_TX = 3'd5;
    localparam logic [2:0] ST_NEXT    = 3'd6;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_A     = 8'h41;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_ZERO + {4'd0, nib};
        end
        return ASCII_A + {4'd0, nib} - 8'd10;
    endfunction

endpackage

// File: rtl/bme280_reg_scanner_uart_tx.sv
// UART 8N1 transmitter: one start bit, eight data bits LSB first, one stop bit,
// each CLKS_PER_BIT cycles. Line idles high and returns high at once on reset.
module uart_tx
    import bme280_reg_scanner_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);

    logic          busy_q, busy_d;
    logic [9:0]    frame_q, frame_d;
    logic [3:0]    bit_q, bit_d;
    logic [CW-1:0] clk_q, clk_d;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        busy_d  = busy_q;
        frame_d = frame_q;
        bit_d   = bit_q;
        clk_d   = clk_q;
        if (!busy_q) begin
            if (tx_valid) begin
                busy_d  = 1'b1;
                frame_d = {1'b1, tx_data, 1'b0};
                bit_d   = 4'd0;
                clk_d   = '0;
            end
        end else if (clk_q == CLK_LAST) begin
            clk_d = '0;
            if (bit_q == 4'd9) begin
                busy_d = 1'b0;
            end else begin
                frame_d = {1'b1, frame_q[9:1]};
                bit_d   = bit_q + 4'd1;
            end
        end else begin
            clk_d = clk_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= 1'b0;
            frame_q <= '0;
            bit_q   <= '0;
            clk_q   <= '0;
        end else begin
            busy_q  <= busy_d;
            frame_q <= frame_d;
            bit_q   <= bit_d;
            clk_q   <= clk_d;
        end
    end

    assign tx_ready = !busy_q;
    assign tx       = busy_q ? frame_q[0] : 1'b1;

endmodule

// File: rtl/bme280_reg_scanner.sv
// Sweeps register selectors 0..NUM_REGS-1, samples each byte after a dwell and
// streams it over UART. Define HEX_ASCII_EN for "HH " text output with CR LF per sweep.
module bme280_reg_scanner
    import bme280_reg_scanner_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int NUM_REGS     = 16,
    parameter int DWELL_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       continuous,
    input  logic [7:0] data,
    output logic [4:0] register_selector,
    output logic       tx,
    output logic       busy,
    output logic       sweep_done
);

    localparam int DW = $clog2(DWELL_CYCLES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [4:0]    LAST_IDX   = 5'(NUM_REGS - 1);

    logic [2:0]    state_q, state_d;
    logic [4:0]    index_q, index_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [7:0]    capture_q, capture_d;
    logic [2:0]    char_q, char_d;

    logic       last_reg;
    logic [2:0] last_char;
    logic [7:0] tx_char;
    logic       tx_valid;
    logic       tx_ready;

    assign last_reg = (index_q == LAST_IDX);

`ifdef HEX_ASCII_EN
    // Two hex digits and a space per byte; the final byte also carries CR LF.
    assign last_char = last_reg ? 3'd4 : 3'd2;

    always_comb begin
        case (char_q)
            3'd0:    tx_char = hex_char(capture_q[7:4]);
            3'd1:    tx_char = hex_char(capture_q[3:0]);
            3'd2:    tx_char = ASCII_SPACE;
            3'd3:    tx_char = ASCII_CR;
            default: tx_char = ASCII_LF;
        endcase
    end
`else
    assign last_char = 3'd0;
    assign tx_char   = capture_q;
`endif

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        dwell_d   = dwell_q;
        capture_d = capture_q;
        char_d    = char_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SELECT;
                    index_d = '0;
                end
            end
            ST_SELECT: begin
                dwell_d = '0;
                state_d = ST_DWELL;
            end
            ST_DWELL: begin
                if (dwell_q == DWELL_LAST) begin
                    state_d = ST_CAPTURE;
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            ST_CAPTURE: begin
                capture_d = data;
                char_d    = '0;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                state_d = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (tx_ready) begin
                    if (char_q == last_char) begin
                        state_d = ST_NEXT;
                    end else begin
                        char_d  = char_q + 3'd1;
                        state_d = ST_SEND;
                    end
                end
            end
            ST_NEXT: begin
                // The selector moves on this edge so a restarted sweep shows index 0 immediately.
                if (last_reg) begin
                    index_d = '0;
                    state_d = continuous ? ST_SELECT : ST_IDLE;
                end else begin
                    index_d = index_q + 5'd1;
                    state_d = ST_SELECT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            index_q   <= '0;
            dwell_q   <= '0;
            capture_q <= '0;
            char_q    <= '0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            dwell_q   <= dwell_d;
            capture_q <= capture_d;
            char_q    <= char_d;
        end
    end

    assign tx_valid          = (state_q == ST_SEND);
    assign register_selector = index_q;
    assign sweep_done        = (state_q == ST_NEXT) && last_reg;
    assign busy              = (state_q != ST_IDLE) && !(sweep_done && !continuous);

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_char),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx      (tx)
    );

endmodule

// File: doc/bme280_reg_scanner.md
BME280_REG_SCANNER -- requirements
Module: bme280_reg_scanner

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, SHALL set the number of clk cycles per UART bit (115200 baud at 50 MHz).
REQ-002 Parameter NUM_REGS, default 16, range 1..32, SHALL set the count of register selector codes swept per pass.
REQ-003 Parameter DWELL_CYCLES, default 50000, minimum 1, SHALL set the number of cycles to wait after each selector change before sampling data.
REQ-004 clk  input  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-005 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 start  input  1  SHALL be a single-cycle request to begin one sweep; ignored while busy.
REQ-007 continuous  input  1  SHALL, when high at the end of a sweep, cause the next sweep to begin immediately.
REQ-008 data  input  8  SHALL be the register byte produced by the I2C wrapper for the current selector.
REQ-009 register_selector  output  5  SHALL drive the wrapper's register selector.
REQ-010 tx  output  1  SHALL be the UART 8N1 serial line, idle high.
REQ-011 busy  output  1  SHALL be high from sweep start until the last UART stop bit completes.
REQ-012 sweep_done  output  1  SHALL pulse high for exactly one cycle when a sweep's final character finishes.

Function
REQ-013 The FSM SHALL use states IDLE, SELECT, DWELL, CAPTURE, SEND, WAIT_TX, NEXT.
REQ-014 IDLE -> SELECT on start=1; SELECT loads register_selector with index 0 and clears the dwell counter.
REQ-015 DWELL SHALL count exactly DWELL_CYCLES cycles, then go to CAPTURE, which registers data in one cycle.
REQ-016 SEND SHALL hand each character to the UART sub-module with a one-cycle valid; WAIT_TX SHALL hold until its ready returns high.
REQ-017 NEXT SHALL increment the index; if index+1 == NUM_REGS the sweep ends, otherwise -> SELECT with the new index.
REQ-018 At sweep end: sweep_done pulses; continuous=1 -> SELECT with index 0, otherwise -> IDLE with busy low.
REQ-019 The UART frame SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each exactly CLKS_PER_BIT cycles.
REQ-020 register_selector SHALL not change while DWELL, CAPTURE, SEND or WAIT_TX is active.
REQ-021 A start pulse coincident with the sweep-end cycle SHALL be ignored; only continuous governs restart.
REQ-022 Changes on data after CAPTURE SHALL not affect the characters in flight.

Reset
REQ-023 While rst=1: state=IDLE, register_selector=0, tx=1, busy=0, sweep_done=0, all counters and the capture register = 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately with tx=1; no partial resumption after release.

Configuration
REQ-025 With HEX_ASCII_EN defined: each captured byte SHALL be sent as two uppercase ASCII hex characters (high nibble first) followed by a space (0x20), and each sweep SHALL end with CR (0x0D) then LF (0x0A).
REQ-026 Without HEX_ASCII_EN: each captured byte SHALL be sent as a single raw byte, with no separators or line terminators.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding, the ASCII constants (space, CR, LF, '0', 'A') and the default CLKS_PER_BIT.
REQ-028 The UART transmitter SHALL be a sub-module, uart_tx (ports: clk, rst, tx_data[7:0], tx_valid, tx_ready, tx), instantiated once.

Verification
REQ-029 Bench runs with CLKS_PER_BIT=4, DWELL_CYCLES=8, NUM_REGS=4, and data driven as 8'hA5 ^ register_selector.
REQ-030 Raw mode, start pulse -> bytes A5, A4, A7, A6 decoded on tx, each 40 cycles; sweep_done pulses once; busy falls the same cycle.
REQ-031 HEX_ASCII_EN, start -> tx stream "A5 A4 A7 A6 \r\n" (14 characters), register_selector steps 0, 1, 2, 3.
REQ-032 continuous=1 -> a second sweep begins with register_selector=0 in the cycle after sweep_done; busy stays high throughout.
REQ-033 start pulsed during DWELL of index 1 -> no effect; the sequence and character count are unchanged.
REQ-034 rst asserted in the 5th data bit of the second character -> tx=1 and register_selector=0 at once; after release with no start, tx stays 1 for 200 cycles.
